// File: rtl/gpr_hilo_file.sv
// -----------------------------------------------------------------------------
// gpr_hilo_file
//   Architectural state at the write-back end of the pipeline: a 32x32
//   general-purpose register file (r0 hard-wired to zero) plus the HI/LO pair.
//   GPR writes and HI/LO writes commit on the rising clock edge and are
//   independent of each other. Reads are combinational with zero latency.
//
// Optional feature macro: GPR_WRITE_BYPASS_EN
//   Defined   : write-first. A read that hits the GPR being written in the same
//               cycle returns wdata. hi_o/lo_o return hi_i/lo_i while hilo_we=1.
//   Undefined : read-old. Reads return pre-edge contents. A new value becomes
//               visible in the cycle after the write edge.
//   Register update behaviour is the same in both builds.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous reset, active-high. Also forces all read data to 0.
//   we/waddr/wdata   GPR write port from the wb stage. Writes to index 0 are dropped.
//   re1/raddr1       read port 1 request. rdata1 is its data, 0 when disabled.
//   re2/raddr2       read port 2 request. rdata2 is its data, 0 when disabled.
//   hilo_we          HI/LO pair write enable. hi_i/lo_i are always written together.
//   hi_o/lo_o        current HI/LO values
// -----------------------------------------------------------------------------
module gpr_hilo_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;

`ifdef GPR_WRITE_BYPASS_EN
  // A GPR write that will really commit. A write to r0 never hits, so r0 always reads 0.
  logic gpr_wr_s;
  assign gpr_wr_s = we && (waddr != ZERO_ADDR);
`endif

  // GPR storage: a reset clears every entry, and r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_DATA;
      end
    end else begin
      if (we && (waddr != ZERO_ADDR)) begin
        regs_r[waddr] <= wdata;
      end
    end
  end

  // HI/LO storage: both halves always update together. MTHI/MTLO arrive pre-merged.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= ZERO_DATA;
      lo_r <= ZERO_DATA;
    end else if (hilo_we) begin
      hi_r <= hi_i;
      lo_r <= lo_i;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Read port 1 priority: reset, disabled, r0, bypass hit (optional), stored value.
  always_comb begin
    rdata1 = ZERO_DATA;
    if (rst) begin
      rdata1 = ZERO_DATA;
    end else if (!re1) begin
      rdata1 = ZERO_DATA;
    end else if (raddr1 == ZERO_ADDR) begin
      rdata1 = ZERO_DATA;
`ifdef GPR_WRITE_BYPASS_EN
    end else if (gpr_wr_s && (raddr1 == waddr)) begin
      rdata1 = wdata;
`endif
    end else begin
      rdata1 = regs_r[raddr1];
    end
  end

  // Read port 2 uses the same priority chain as port 1.
  always_comb begin
    rdata2 = ZERO_DATA;
    if (rst) begin
      rdata2 = ZERO_DATA;
    end else if (!re2) begin
      rdata2 = ZERO_DATA;
    end else if (raddr2 == ZERO_ADDR) begin
      rdata2 = ZERO_DATA;
`ifdef GPR_WRITE_BYPASS_EN
    end else if (gpr_wr_s && (raddr2 == waddr)) begin
      rdata2 = wdata;
`endif
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end

  // HI/LO read: 0 during reset. Otherwise the stored pair, or the incoming pair
  // when the write-first build sees a write in this cycle.
  always_comb begin
    hi_o = ZERO_DATA;
    lo_o = ZERO_DATA;
    if (rst) begin
      hi_o = ZERO_DATA;
      lo_o = ZERO_DATA;
`ifdef GPR_WRITE_BYPASS_EN
    end else if (hilo_we) begin
      hi_o = hi_i;
      lo_o = lo_i;
`endif
    end else begin
      hi_o = hi_r;
      lo_o = lo_r;
    end
  end

endmodule

// File: tb/tb_gpr_hilo_file.sv
module tb_gpr_hilo_file;

`ifdef GPR_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        hilo_we;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad   = 0;

  gpr_hilo_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hilo_we(hilo_we), .hi_i(hi_i), .lo_i(lo_i),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge. Outputs are checked 1 time unit later,
  // well away from the rising edge.
  initial begin
    rst = 1'b1; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b0; raddr2 = 5'd0;
    hilo_we = 1'b0; hi_i = 32'h0; lo_i = 32'h0;

    // Reset is held for two edges. Outputs are 0 during reset.
    @(negedge clk); #1;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    @(negedge clk);

    // Write r5 and the HI/LO pair, then read them back.
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    hilo_we = 1'b1; hi_i = 32'hAAAA0000; lo_i = 32'h00005555;
    @(negedge clk);
    we = 1'b0; hilo_we = 1'b0; #1;
    chk("r5_written", rdata1, 32'hDEADBEEF);
    chk("hi_pre_rst", hi_o, 32'hAAAA0000);

    // Reset with a coincident write: reset wins, and reads are 0 during reset.
    @(negedge clk);
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h00000012; #1;
    chk("rst_during_rd", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; #1;
    chk("rst_after_rd", rdata1, 32'h0);
    chk("rst_after_hi", hi_o, 32'h0);
    chk("rst_after_lo", lo_o, 32'h0);

    // r0 cannot be changed.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; #1;
    chk("r0_wr_cycle", rdata1, 32'h0);
    @(negedge clk);
    we = 1'b0; #1;
    chk("r0_next1", rdata1, 32'h0);
    @(negedge clk); #1;
    chk("r0_next2", rdata1, 32'h0);

    // Write r7, then read it on both ports and test the port enables.
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    @(negedge clk);
    we = 1'b0; re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7; #1;
    chk("r7_p1", rdata1, 32'h12345678);
    chk("r7_p2", rdata2, 32'h12345678);
    re2 = 1'b0; #1;
    chk("re2_off", rdata2, 32'h0);
    re1 = 1'b0; #1;
    chk("re1_off", rdata1, 32'h0);

    // Read r9 in the same cycle that it is written.
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h11111111;
    @(negedge clk);
    wdata = 32'h22222222; re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd7; #1;
    chk("r9_same_cyc", rdata1, BYP ? 32'h22222222 : 32'h11111111);
    chk("r7_no_hit", rdata2, 32'h12345678);
    @(negedge clk);
    we = 1'b0; #1;
    chk("r9_next_cyc", rdata1, 32'h22222222);

    // HI/LO pair write, then hold when hilo_we=0.
    hilo_we = 1'b1; hi_i = 32'h00000001; lo_i = 32'hFFFFFFFE; #1;
    chk("hi_wr_cyc", hi_o, BYP ? 32'h00000001 : 32'h0);
    chk("lo_wr_cyc", lo_o, BYP ? 32'hFFFFFFFE : 32'h0);
    @(negedge clk);
    hilo_we = 1'b0; hi_i = 32'h00000077; lo_i = 32'h00000088; #1;
    chk("hi_written", hi_o, 32'h00000001);
    chk("lo_written", lo_o, 32'hFFFFFFFE);
    @(negedge clk); #1;
    chk("hi_held", hi_o, 32'h00000001);
    chk("lo_held", lo_o, 32'hFFFFFFFE);

    // GPR and HI/LO writes in the same cycle.
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    hilo_we = 1'b1; hi_i = 32'hC0DE0000; lo_i = 32'h0000C0DE;
    @(negedge clk);
    we = 1'b0; hilo_we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd7; #1;
    chk("sim_r3", rdata1, 32'hA5A5A5A5);
    chk("sim_r7", rdata2, 32'h12345678);
    chk("sim_hi", hi_o, 32'hC0DE0000);
    chk("sim_lo", lo_o, 32'h0000C0DE);
    raddr1 = 5'd9; raddr2 = 5'd5; #1;
    chk("sim_r9", rdata1, 32'h22222222);
    chk("sim_r5", rdata2, 32'h0);

    // With we=0, data on the write port must not change r3.
    waddr = 5'd3; wdata = 32'h00000BAD; raddr1 = 5'd3;
    @(negedge clk); #1;
    chk("we0_hold_r3", rdata1, 32'hA5A5A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
